// File: rtl/store_checker.sv
// rtl/store_checker.sv - first-store verdict checker with timeout and a store-log FIFO
module store_checker #(
  parameter logic [31:0] EXP_ADR  = 32'd84,
  parameter logic [31:0] EXP_DATA = 32'd4,
  parameter int          TIMEOUT  = 1000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        log_ready,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        misaligned,
  output logic        overflow,
  output logic [7:0]  store_count,
  output logic        log_valid,
  output logic [31:0] log_adr,
  output logic [31:0] log_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ARMED, PASS, FAIL} state_t;

  state_t      state, state_nxt;
  logic [15:0] idle, idle_nxt;
  logic        timeout_nxt, misaligned_nxt;

  logic [31:0] mem_adr  [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push;

  always_comb begin
    state_nxt      = state;
    idle_nxt       = idle;
    timeout_nxt    = timeout;
    misaligned_nxt = misaligned;
    if (state == ARMED) begin
      if (memwrite) begin
        // a store always wins over a coincident timeout
        idle_nxt = 16'd0;
        if (dataadr[1:0] != 2'b00) begin
          state_nxt      = FAIL;
          misaligned_nxt = 1'b1;
        end else if (dataadr == EXP_ADR && writedata == EXP_DATA) begin
          state_nxt = PASS;
        end else begin
          state_nxt = FAIL;
        end
      end else if (idle == IDLE_MAX) begin
        state_nxt   = FAIL;
        timeout_nxt = 1'b1;
      end else begin
        idle_nxt = idle + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARMED;
      idle       <= 16'd0;
      timeout    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle       <= idle_nxt;
      timeout    <= timeout_nxt;
      misaligned <= misaligned_nxt;
    end
  end

  assign done = (state != ARMED);
  assign pass = (state == PASS);

  assign full      = (count == FULL_CNT);
  assign log_valid = (count != '0);
  assign pop       = log_valid && log_ready;
  // a full log still accepts a store when the head leaves in the same cycle
  assign push      = memwrite && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      store_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
      if (memwrite && !push) overflow <= 1'b1;
      if (memwrite && store_count != 8'hff) store_count <= store_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_adr[wr_ptr]  <= dataadr;
      mem_data[wr_ptr] <= writedata;
    end
  end

  assign log_adr  = log_valid ? mem_adr[rd_ptr]  : 32'd0;
  assign log_data = log_valid ? mem_data[rd_ptr] : 32'd0;

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter EXP_ADR, default 32'd84, expected byte address of the first store.
REQ-002 Parameter EXP_DATA, default 32'd4, expected data of the first store.
REQ-003 Parameter TIMEOUT, default 1000, idle cycles in ARMED before declaring timeout failure; legal range 2..65535.
REQ-004 Parameter DEPTH, default 4, store-log FIFO entries; power of two, 2..16.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 memwrite  input  1  processor store strobe; one store per cycle when high.
REQ-008 dataadr  input  32  processor store byte address.
REQ-009 writedata  input  32  processor store data.
REQ-010 log_ready  input  1  consumer pops the log head when log_valid && log_ready.
REQ-011 done  output  1  verdict reached (PASS or FAIL); sticky until reset.
REQ-012 pass  output  1  high only in PASS.
REQ-013 timeout  output  1  FAIL entered through timeout; sticky.
REQ-014 misaligned  output  1  FAIL entered through a store with dataadr[1:0] != 0; sticky.
REQ-015 overflow  output  1  a store was dropped because the log was full; sticky.
REQ-016 store_count  output  8  stores seen since reset, saturating at 255.
REQ-017 log_valid  output  1  log not empty.
REQ-018 log_adr  output  32  head-entry address; 0 when empty.
REQ-019 log_data  output  32  head-entry data; 0 when empty.

Function
REQ-020 State machine states: ARMED, PASS, FAIL; reset enters ARMED; PASS and FAIL are terminal until reset.
REQ-021 In ARMED, a sampled store with dataadr[1:0] != 0 -> FAIL, misaligned=1.
REQ-022 In ARMED, an aligned store with dataadr == EXP_ADR and writedata == EXP_DATA (full 32-bit compares) -> PASS; any other aligned store -> FAIL.
REQ-023 Verdict latency: done/pass/flags registered, visible immediately after the rising edge that samples the deciding store.
REQ-024 Idle counter (16 bit) increments on each ARMED cycle without memwrite and clears on a store; when it equals TIMEOUT-1 and memwrite is low, next edge -> FAIL, timeout=1.
REQ-025 Store and timeout in the same cycle: the store decides; timeout stays 0.
REQ-026 Every store, in any state, increments store_count (saturating at 255, no wrap) and is pushed to the log if not full.
REQ-027 Log is first-in first-out; head visible combinationally from registered storage; pop on log_valid && log_ready.
REQ-028 Push while full with no pop: store dropped, overflow=1, stored entries unchanged.
REQ-029 Push and pop in the same cycle while full: both take effect, occupancy stays DEPTH, overflow unchanged.
REQ-030 Pop while empty: ignored, no pointer movement.
REQ-031 Pointer wrap-around at DEPTH is seamless; occupancy tracked with a count of width log2(DEPTH)+1.
REQ-032 Outputs depend only on registered state, not combinationally on memwrite/dataadr/writedata.

Reset
REQ-033 While reset is high: state=ARMED; done, pass, timeout, misaligned, overflow, log_valid=0; store_count, log_adr, log_data, idle counter, pointers, occupancy=0.
REQ-034 Reset asserted mid-operation (any state, log partly full) clears everything within the same cycle, without waiting for a clock edge; memwrite is ignored while reset is high.
REQ-035 First sampling edge is the first rising edge with reset low.

Verification
REQ-036 10 ns clk, reset high for 22 ns, single store (84, 4) -> next edge: done=1, pass=1, store_count=1, log head (84, 4).
REQ-037 Single store (84, 5) -> done=1, pass=0, timeout=0, misaligned=0; a following store (84, 4) leaves the verdict unchanged and store_count=2.
REQ-038 Store (86, 4) -> done=1, pass=0, misaligned=1.
REQ-039 TIMEOUT=16, no stores -> done=1 and timeout=1 right after the 16th post-reset edge, not earlier; a store on cycle 16 yields a store verdict instead.
REQ-040 DEPTH=4, log_ready=0, five stores (A0..A4) -> overflow=1, occupancy 4, pops return A0..A3 in order; full push+pop in one cycle keeps occupancy 4, overflow unchanged.
REQ-041 Reset pulsed mid-cycle in PASS with 3 logged entries -> all outputs 0 before the next edge; subsequent store (84, 4) -> PASS again.
